// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register map, field positions, exception codes and
// the COP0/SPECIAL encodings decoded by cp0_unit.
package cp0_defs;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;

   // Status.IM[7:2] and Cause.IP[7:2] share bit positions so they can be ANDed directly.
   localparam int ST_IE   = 0;
   localparam int ST_EXL  = 1;
   localparam int IP_LO   = 10;
   localparam int IP_HI   = 15;
   localparam int SWIP_LO = 8;
   localparam int SWIP_HI = 9;
   localparam int EXC_LO  = 2;
   localparam int EXC_HI  = 6;

   localparam logic [5:0] OP_COP0    = 6'b010000;
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [4:0] RS_MFC0    = 5'b00000;
   localparam logic [4:0] RS_MTC0    = 5'b00100;
   localparam logic [5:0] FN_ERET    = 6'b011000;
   localparam logic [5:0] FN_SYSCALL = 6'b001100;

   typedef enum logic [4:0] {
      EXC_INT = 5'd0,
      EXC_SYS = 5'd8,
      EXC_OV  = 5'd12
   } exc_code_e;

   typedef struct packed {
      logic [5:0] im;
      logic       exl;
      logic       ie;
   } status_t;

   function automatic logic [31:0] status_word(input status_t s);
      logic [31:0] w;
      w                = '0;
      w[IP_HI:IP_LO]   = s.im;
      w[ST_EXL]        = s.exl;
      w[ST_IE]         = s.ie;
      return w;
   endfunction

   function automatic logic [31:0] cause_word(input logic [7:0] ip, input exc_code_e code);
      logic [31:0] w;
      w                  = '0;
      w[IP_HI:SWIP_LO]   = ip;
      w[EXC_HI:EXC_LO]   = code;
      return w;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: free-running counter with a sticky compare-match flag
// that feeds Cause.IP7.
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_wr_count,
   input  logic        i_wr_compare,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_count,
   output logic [31:0] o_compare,
   output logic        o_timer_pending
);

   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_timer_pending;
   logic        w_match;

   // Compare == 0 is the disarmed state, so a reset timer never fires.
   assign w_match = (r_count == r_compare) && (r_compare != '0);

   // NOTE: non-blocking assignments make every register sample pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count         <= '0;
         r_compare       <= '0;
         r_timer_pending <= 1'b0;
      end else begin
         r_count <= i_wr_count ? i_wdata : r_count + 32'd1;
         if (i_wr_compare) begin
            r_compare       <= i_wdata;
            r_timer_pending <= 1'b0;
         end else if (w_match) begin
            r_timer_pending <= 1'b1;
         end
      end
   end

   assign o_count         = r_count;
   assign o_compare       = r_compare;
   assign o_timer_pending = r_timer_pending;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 for the single-cycle MIPS core: Status/Cause/EPC, interrupt
// sampling, exception entry and eret exit, mfc0/mtc0 access.
module cp0_unit
   import cp0_defs::*;
#(
   parameter int NUM_HW_INT = 6,
   parameter int TIMER_EN   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           pc,
   input  logic [31:0]           inst,
   input  logic [31:0]           rt_data,
   input  logic                  overflow,
   input  logic [NUM_HW_INT-1:0] int_in,
   output logic                  exception,
   output logic                  exc_squash,
   output logic [31:0]           epc,
   output logic [31:0]           cp0_rdata,
   output logic                  int_pending
);

   status_t     r_status;
   logic [7:0]  r_ip;
   exc_code_e   r_exc_code;
   logic [31:0] r_epc;

   logic [4:0]  w_rd;
   logic        w_is_mfc0, w_is_mtc0, w_is_eret, w_is_syscall;
   logic        w_take_int, w_exc_raw, w_wr_en;
   exc_code_e   w_exc_code;
   logic [5:0]  w_hw_ip;
   logic [31:0] w_count, w_compare, w_rdata;
   logic        w_timer_pending;
   logic        w_unused;

   assign w_rd         = inst[15:11];
   assign w_is_mfc0    = (inst[31:26] == OP_COP0) && (inst[25:21] == RS_MFC0);
   assign w_is_mtc0    = (inst[31:26] == OP_COP0) && (inst[25:21] == RS_MTC0);
   assign w_is_eret    = (inst[31:26] == OP_COP0) && (inst[5:0] == FN_ERET);
   assign w_is_syscall = (inst[31:26] == OP_SPECIAL) && (inst[5:0] == FN_SYSCALL);
   assign w_unused     = ^{inst[20:16], inst[10:6]};

   assign w_take_int = r_status.ie & ~r_status.exl & (|(r_ip[7:2] & r_status.im));
   // eret holds off interrupts for one cycle so the handler exit completes first.
   assign w_exc_raw  = overflow | w_is_syscall | (w_take_int & ~w_is_eret);
   assign w_wr_en    = w_is_mtc0 & ~w_exc_raw;

   assign exception   = ~rst & w_exc_raw;
   assign exc_squash  = ~rst & overflow;
   assign int_pending = w_take_int;
   assign epc         = r_epc;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_exc_code = EXC_INT;
      if (overflow)          w_exc_code = EXC_OV;
      else if (w_is_syscall) w_exc_code = EXC_SYS;
   end

   always_comb begin
      w_hw_ip = '0;
      for (int k = 0; k < NUM_HW_INT - 1; k++) w_hw_ip[k] = int_in[k];
      w_hw_ip[5] = int_in[NUM_HW_INT-1] | w_timer_pending;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_status   <= '0;
         r_ip       <= '0;
         r_exc_code <= EXC_INT;
         r_epc      <= '0;
      end else begin
         r_ip[7:2] <= w_hw_ip;
         if (w_exc_raw) begin
            r_exc_code   <= w_exc_code;
            r_status.exl <= 1'b1;
            // Nested synchronous faults keep the outer handler's return address.
            if (!r_status.exl) r_epc <= overflow ? pc : pc + 32'd4;
         end else begin
            if (w_is_eret) r_status.exl <= 1'b0;
            if (w_wr_en) begin
               case (w_rd)
                  REG_STATUS: r_status <= '{im:  rt_data[IP_HI:IP_LO],
                                            exl: rt_data[ST_EXL],
                                            ie:  rt_data[ST_IE]};
                  REG_CAUSE:  r_ip[1:0] <= rt_data[SWIP_HI:SWIP_LO];
                  REG_EPC:    r_epc <= rt_data;
                  default:    ;
               endcase
            end
         end
      end
   end

   generate
      if (TIMER_EN != 0) begin : g_timer
         cp0_timer u_timer (
            .clk             (clk),
            .rst             (rst),
            .i_wr_count      (w_wr_en && (w_rd == REG_COUNT)),
            .i_wr_compare    (w_wr_en && (w_rd == REG_COMPARE)),
            .i_wdata         (rt_data),
            .o_count         (w_count),
            .o_compare       (w_compare),
            .o_timer_pending (w_timer_pending)
         );
      end else begin : g_no_timer
         assign w_count         = '0;
         assign w_compare       = '0;
         assign w_timer_pending = 1'b0;
      end
   endgenerate

   always_comb begin
      w_rdata = '0;
      if (w_is_mfc0) begin
         case (w_rd)
            REG_COUNT:   w_rdata = w_count;
            REG_COMPARE: w_rdata = w_compare;
            REG_STATUS:  w_rdata = status_word(r_status);
            REG_CAUSE:   w_rdata = cause_word(r_ip, r_exc_code);
            REG_EPC:     w_rdata = r_epc;
            default:     w_rdata = '0;
         endcase
      end
   end

   assign cp0_rdata = w_rdata;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: a word-level CP0 register-map model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, inst, rt_data;
   logic        overflow;
   logic [5:0]  int_in;
   logic        exception, exc_squash, int_pending;
   logic [31:0] epc, cp0_rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [31:0] NOP     = 32'h0000_0000;
   localparam logic [31:0] SYSCALL = 32'h0000_000C;
   localparam logic [31:0] ERET    = 32'h4200_0018;

   cp0_unit #(.NUM_HW_INT(6), .TIMER_EN(1)) dut (
      .clk(clk), .rst(rst), .pc(pc), .inst(inst), .rt_data(rt_data),
      .overflow(overflow), .int_in(int_in), .exception(exception),
      .exc_squash(exc_squash), .epc(epc), .cp0_rdata(cp0_rdata),
      .int_pending(int_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mfc0(input logic [4:0] rd);
      return {11'h200, 5'd0, rd, 11'd0};
   endfunction

   function automatic logic [31:0] mtc0(input logic [4:0] rd);
      return {11'h204, 5'd0, rd, 11'd0};
   endfunction

   // ---------------- behavioural model: CP0 as a 32-entry word map ----------------
   logic [31:0] m_cp0 [0:31];
   bit          m_tpend;
   bit          m_valid = 1'b0;

   function automatic bit f_mfc0(input logic [31:0] i); return i[31:21] == 11'h200; endfunction
   function automatic bit f_mtc0(input logic [31:0] i); return i[31:21] == 11'h204; endfunction
   function automatic bit f_eret(input logic [31:0] i); return i[31:26] == 6'h10 && i[5:0] == 6'h18; endfunction
   function automatic bit f_sys(input logic [31:0] i);  return i[31:26] == 6'h00 && i[5:0] == 6'h0C; endfunction

   // Bits software may change in each register.
   function automatic logic [31:0] f_wmask(input logic [4:0] rd);
      case (rd)
         5'd9, 5'd11, 5'd14: return 32'hFFFF_FFFF;
         5'd12:              return 32'h0000_FC03;
         5'd13:              return 32'h0000_0300;
         default:            return 32'h0;
      endcase
   endfunction

   function automatic bit f_take_int();
      logic [31:0] st;
      st = m_cp0[12];
      return st[0] && !st[1] && ((m_cp0[13] & st & 32'h0000_FC00) != 0);
   endfunction

   function automatic bit f_exc();
      return !rst && (overflow || f_sys(inst) || (f_take_int() && !f_eret(inst)));
   endfunction

   function automatic logic [31:0] f_rdata();
      return f_mfc0(inst) ? m_cp0[inst[15:11]] : 32'h0;
   endfunction

   always @(posedge clk) begin : model_step
      logic [31:0] old [0:31];
      logic [31:0] mask, code;
      logic [4:0]  rd;
      bit          otp, exc, wr;
      old = m_cp0;
      otp = m_tpend;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_cp0[i] = 32'h0;
         m_tpend = 1'b0;
         m_valid = 1'b1;
      end else begin
         rd   = inst[15:11];
         exc  = f_exc();
         wr   = f_mtc0(inst) && !exc;
         mask = f_wmask(rd);
         if (wr) m_cp0[rd] = (old[rd] & ~mask) | (rt_data & mask);
         if (!(wr && rd == 5'd9)) m_cp0[9] = old[9] + 32'd1;
         if (wr && rd == 5'd11)                         m_tpend = 1'b0;
         else if (old[9] == old[11] && old[11] != 0)    m_tpend = 1'b1;
         if (exc) begin
            code      = overflow ? 32'd12 : (f_sys(inst) ? 32'd8 : 32'd0);
            m_cp0[13] = (old[13] & ~32'h7C) | (code << 2);
            m_cp0[12] = old[12] | 32'h2;
            if (!old[12][1]) m_cp0[14] = overflow ? pc : pc + 32'd4;
         end else if (f_eret(inst)) begin
            m_cp0[12] = old[12] & ~32'h2;
         end
         m_cp0[13] = (m_cp0[13] & ~32'hFC00) | ({26'b0, int_in[5] | otp, int_in[4:0]} << 10);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("exception",   {31'b0, exception},   {31'b0, f_exc()});
         check("exc_squash",  {31'b0, exc_squash},  {31'b0, !rst && overflow});
         check("int_pending", {31'b0, int_pending}, {31'b0, f_take_int()});
         check("epc",         epc,                  m_cp0[14]);
         check("cp0_rdata",   cp0_rdata,            f_rdata());
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input logic [31:0] a_pc, input logic [31:0] a_inst,
                        input logic [31:0] a_rt, input logic a_ov);
      pc = a_pc; inst = a_inst; rt_data = a_rt; overflow = a_ov;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] found;
      rst = 1'b1; pc = '0; inst = NOP; rt_data = '0; overflow = 1'b1; int_in = '0;

      // Reset: two cycles with overflow held high.
      tick();
      check("rst_exception", {31'b0, exception},  32'h0);
      check("rst_squash",    {31'b0, exc_squash}, 32'h0);
      tick();
      rst = 1'b0;
      drive(32'h0, mfc0(5'd12), 32'h0, 1'b0); check("rst_status", cp0_rdata, 32'h0); tick();
      drive(32'h0, mfc0(5'd13), 32'h0, 1'b0); check("rst_cause",  cp0_rdata, 32'h0); tick();
      drive(32'h0, mfc0(5'd14), 32'h0, 1'b0); check("rst_epc",    cp0_rdata, 32'h0);
      check("rst_epc_port", epc, 32'h0); tick();

      // Syscall entry and eret exit.
      drive(32'h100, SYSCALL, 32'h0, 1'b0);
      check("sys_exception", {31'b0, exception},  32'h1);
      check("sys_squash",    {31'b0, exc_squash}, 32'h0);
      tick();
      drive(32'h104, mfc0(5'd13), 32'h0, 1'b0);
      check("sys_epc", epc, 32'h104); check("sys_cause", cp0_rdata, 32'h20); tick();
      drive(32'h108, mfc0(5'd12), 32'h0, 1'b0); check("sys_status_exl", cp0_rdata, 32'h2); tick();
      drive(32'h10C, ERET, 32'h0, 1'b0); check("eret_no_exc", {31'b0, exception}, 32'h0); tick();
      drive(32'h104, mfc0(5'd12), 32'h0, 1'b0);
      check("eret_status", cp0_rdata, 32'h0); check("eret_epc", epc, 32'h104); tick();

      // Enabled interrupt on IM2.
      drive(32'h10, mtc0(5'd12), 32'h401, 1'b0); tick();
      int_in = 6'b000001;
      drive(32'h20, NOP, 32'h0, 1'b0); check("int_not_yet", {31'b0, exception}, 32'h0); tick();
      drive(32'h24, NOP, 32'h0, 1'b0); check("int_taken", {31'b0, exception}, 32'h1); tick();
      drive(32'h28, mfc0(5'd13), 32'h0, 1'b0);
      check("int_epc", epc, 32'h28); check("int_cause", cp0_rdata, 32'h400); tick();
      drive(32'h2C, mfc0(5'd12), 32'h0, 1'b0); check("int_status", cp0_rdata, 32'h403); tick();
      int_in = '0;
      drive(32'h30, ERET, 32'h0, 1'b0); tick();

      // Same input with IM2 cleared stays masked.
      drive(32'h40, mtc0(5'd12), 32'h1, 1'b0); tick();
      int_in = 6'b000001;
      for (int i = 0; i < 3; i++) begin
         drive(32'h44 + 32'(i) * 4, NOP, 32'h0, 1'b0);
         check("masked_no_exc", {31'b0, exception}, 32'h0);
         tick();
      end
      int_in = '0;
      drive(32'h50, NOP, 32'h0, 1'b0); tick();

      // Overflow beats a pending interrupt; interrupt follows one cycle after eret.
      int_in = 6'b000001;
      drive(32'h1F0, mtc0(5'd12), 32'h401, 1'b0); tick();
      drive(32'h200, NOP, 32'h0, 1'b1);
      check("ov_exception", {31'b0, exception},  32'h1);
      check("ov_squash",    {31'b0, exc_squash}, 32'h1);
      tick();
      drive(32'h200, mfc0(5'd13), 32'h0, 1'b0);
      check("ov_epc", epc, 32'h200); check("ov_cause", cp0_rdata, 32'h430); tick();
      drive(32'h204, ERET, 32'h0, 1'b0); check("eret_holdoff", {31'b0, exception}, 32'h0); tick();
      drive(32'h210, NOP, 32'h0, 1'b0); check("int_after_eret", {31'b0, exception}, 32'h1); tick();
      drive(32'h214, NOP, 32'h0, 1'b0); check("int_after_eret_epc", epc, 32'h214); tick();
      int_in = '0;
      drive(32'h218, ERET, 32'h0, 1'b0); tick();
      drive(32'h21C, NOP, 32'h0, 1'b0); tick();

      // Timer: Count=0, Compare=5, IM7 enabled.
      drive(32'h3F0, mtc0(5'd9),  32'h0,    1'b0); tick();
      drive(32'h3F4, mtc0(5'd11), 32'h5,    1'b0); tick();
      drive(32'h3F8, mtc0(5'd12), 32'h8001, 1'b0); tick();
      found = 32'hFFFF_FFFF;
      for (int i = 0; i < 12; i++) begin
         drive(32'h400 + 32'(i) * 4, NOP, 32'h0, 1'b0);
         if (exception) found = 32'(i);
         tick();
         if (found != 32'hFFFF_FFFF) break;
      end
      check("timer_exc_cycle", found, 32'd5);
      drive(32'h500, mfc0(5'd13), 32'h0, 1'b0);
      check("timer_epc", epc, 32'h418); check("timer_cause", cp0_rdata, 32'h8000); tick();
      drive(32'h504, mtc0(5'd11), 32'h20, 1'b0); tick();
      drive(32'h508, mfc0(5'd13), 32'h0, 1'b0); check("ip7_still", cp0_rdata, 32'h8000); tick();
      drive(32'h50C, mfc0(5'd13), 32'h0, 1'b0); check("ip7_cleared", cp0_rdata, 32'h0); tick();

      // mtc0 EPC colliding with an overflow is discarded.
      drive(32'h510, ERET, 32'h0, 1'b0); tick();
      drive(32'h300, mtc0(5'd14), 32'hDEAD, 1'b1);
      check("coll_exception", {31'b0, exception}, 32'h1); tick();
      drive(32'h304, mfc0(5'd14), 32'h0, 1'b0);
      check("coll_epc", epc, 32'h300); check("coll_rdata", cp0_rdata, 32'h300); tick();

      // Reset inside the handler clears EXL.
      rst = 1'b1;
      drive(32'h308, NOP, 32'h0, 1'b0); check("rst_mid_exc", {31'b0, exception}, 32'h0); tick();
      rst = 1'b0;
      drive(32'h0, mfc0(5'd12), 32'h0, 1'b0); check("rst_clears_exl", cp0_rdata, 32'h0); tick();
      drive(32'h4, NOP, 32'h0, 1'b0); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
